// File: rtl/pingpong_nbank_stream.sv
`timescale 1ns/1ps
// N-bank ping-pong capture buffer: banks are filled in rotation and full banks are drained as an AXI-Stream.
// Latency: bank full -> m_tvalid in 2 clk; 1 word/clk while m_tready=1. Writer has no backpressure; words arriving while it is blocked are dropped.
module pingpong_nbank_stream #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4096,
    parameter int NUM_BANKS = 2,
    localparam int CW       = $clog2(NUM_BANKS + 1)
) (
    input  logic              clk_50m,
    input  logic              usr_rst_n,
    input  logic              soft_rst,
    input  logic              run_en,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic [CW-1:0]     full_banks,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NUM_BANKS);

    typedef enum logic {W_FILL, W_BLOCKED} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

    wstate_t               wst_q;
    rstate_t               rst_q;
    logic [BW-1:0]         wr_bank_q, rd_bank_q;
    logic [AW-1:0]         wr_addr_q, fetch_addr_q;
    logic                  fetch_done_q;
    logic [NUM_BANKS-1:0]  bank_full_q, bank_full_d;
    logic [NUM_BANKS-1:0]  bank_set, bank_clr;
    logic [CW-1:0]         full_banks_q, full_cnt_d;
    logic                  overflow_q;
    logic [15:0]           drop_cnt_q;
    logic                  m_tvalid_q, m_tlast_q;
    logic [DATA_W-1:0]     m_tdata_q;
    logic                  pend_q, pend_last_q;
    logic [DATA_W-1:0]     ram_dout_q;

    logic [DATA_W-1:0]     mem [NUM_BANKS*DEPTH];

    logic [BW-1:0]         wr_next_bank, rd_next_bank, issue_bank;
    logic [AW-1:0]         issue_addr;
    logic                  wr_en, wr_last, rd_issue, rd_en;
    logic                  pop, out_keep, move, last_acc;

    assign wr_next_bank = (wr_bank_q == BW'(NUM_BANKS - 1)) ? '0 : wr_bank_q + BW'(1);
    assign rd_next_bank = (rd_bank_q == BW'(NUM_BANKS - 1)) ? '0 : rd_bank_q + BW'(1);
    assign wr_last      = (wr_addr_q == AW'(DEPTH - 1));
    assign wr_en        = wr_valid && (wst_q == W_FILL) && !soft_rst;

    // The RAM output register doubles as the skid stage: it holds its word until the output slot frees.
    assign pop      = m_tvalid_q && m_tready;
    assign out_keep = m_tvalid_q && !m_tready;
    assign move     = pend_q && !out_keep && run_en;
    assign last_acc = pop && m_tlast_q;
    assign rd_en    = rd_issue && !soft_rst;

    always_comb begin
        bank_set = '0;
        if (wr_en && wr_last) bank_set[wr_bank_q] = 1'b1;
    end

    always_comb begin
        rd_issue   = 1'b0;
        issue_bank = rd_bank_q;
        issue_addr = fetch_addr_q;
        bank_clr   = '0;
        if (last_acc) begin
            bank_clr[rd_bank_q] = 1'b1;
            issue_bank          = rd_next_bank;
            issue_addr          = '0;
            rd_issue            = bank_full_q[rd_next_bank] && run_en;
        end else if (rst_q == R_IDLE) begin
            issue_addr = '0;
            rd_issue   = bank_full_q[rd_bank_q] && run_en;
        end else begin
            rd_issue = !fetch_done_q && run_en && !(pend_q && !move);
        end
    end

    assign bank_full_d = (bank_full_q & ~bank_clr) | bank_set;

    always_comb begin
        full_cnt_d = '0;
        for (int i = 0; i < NUM_BANKS; i++) full_cnt_d = full_cnt_d + CW'(bank_full_d[i]);
    end

    always_ff @(posedge clk_50m) begin
        if (wr_en) mem[{wr_bank_q, wr_addr_q}] <= wr_data;
        if (rd_en) ram_dout_q <= mem[{issue_bank, issue_addr}];
    end

    always_ff @(posedge clk_50m or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            wst_q        <= W_FILL;
            rst_q        <= R_IDLE;
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            wr_addr_q    <= '0;
            fetch_addr_q <= '0;
            fetch_done_q <= 1'b0;
            bank_full_q  <= '0;
            full_banks_q <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
        end else if (soft_rst) begin
            wst_q        <= W_FILL;
            rst_q        <= R_IDLE;
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            wr_addr_q    <= '0;
            fetch_addr_q <= '0;
            fetch_done_q <= 1'b0;
            bank_full_q  <= '0;
            full_banks_q <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
        end else begin
            case (wst_q)
                W_FILL: begin
                    if (wr_valid) begin
                        if (wr_last) begin
                            wr_addr_q <= '0;
                            wr_bank_q <= wr_next_bank;
                            if (bank_full_q[wr_next_bank]) wst_q <= W_BLOCKED;
                        end else begin
                            wr_addr_q <= wr_addr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    if (wr_valid) begin
                        overflow_q <= 1'b1;
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                    if (!bank_full_q[wr_bank_q]) wst_q <= W_FILL;
                end
            endcase

            bank_full_q  <= bank_full_d;
            full_banks_q <= full_cnt_d;

            if (rd_en) begin
                fetch_addr_q <= issue_addr + AW'(1);
                fetch_done_q <= (issue_addr == AW'(DEPTH - 1));
                pend_last_q  <= (issue_addr == AW'(DEPTH - 1));
            end
            pend_q <= rd_en || (pend_q && !move);

            if (move) begin
                m_tdata_q <= ram_dout_q;
                m_tlast_q <= pend_last_q;
            end else if (pop) begin
                m_tlast_q <= 1'b0;
            end
            m_tvalid_q <= out_keep || move;

            if (last_acc) rd_bank_q <= rd_next_bank;

            case (rst_q)
                R_IDLE:   if (rd_en) rst_q <= R_FETCH;
                R_FETCH:  if (move) rst_q <= R_STREAM;
                default:  if (last_acc) rst_q <= rd_en ? R_FETCH : R_IDLE;
            endcase
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tlast    = m_tlast_q;
    assign full_banks = full_banks_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_pingpong_nbank_stream.sv
`timescale 1ns/1ps
// Bench for pingpong_nbank_stream: a 2-bank and a 4-bank instance (DEPTH=16, 8-bit data),
// directed stimulus feeding per-instance expected-word queues that negedge monitors check.
module tb_pingpong_nbank_stream;
    logic clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    logic       usr_rst_n;
    logic       a_soft_rst, a_run_en, a_wr_valid, a_tready;
    logic [7:0] a_wr_data, a_tdata;
    logic       a_tvalid, a_tlast, a_ovf;
    logic [1:0] a_full;
    logic [15:0] a_drop;

    logic       b_soft_rst, b_run_en, b_wr_valid, b_tready;
    logic [7:0] b_wr_data, b_tdata;
    logic       b_tvalid, b_tlast, b_ovf;
    logic [2:0] b_full;
    logic [15:0] b_drop;

    pingpong_nbank_stream #(.DATA_W(8), .DEPTH(16), .NUM_BANKS(2)) dut_a (
        .clk_50m(clk_50m), .usr_rst_n(usr_rst_n), .soft_rst(a_soft_rst), .run_en(a_run_en),
        .wr_valid(a_wr_valid), .wr_data(a_wr_data), .m_tvalid(a_tvalid), .m_tready(a_tready),
        .m_tdata(a_tdata), .m_tlast(a_tlast), .full_banks(a_full), .overflow(a_ovf), .drop_cnt(a_drop));

    pingpong_nbank_stream #(.DATA_W(8), .DEPTH(16), .NUM_BANKS(4)) dut_b (
        .clk_50m(clk_50m), .usr_rst_n(usr_rst_n), .soft_rst(b_soft_rst), .run_en(b_run_en),
        .wr_valid(b_wr_valid), .wr_data(b_wr_data), .m_tvalid(b_tvalid), .m_tready(b_tready),
        .m_tdata(b_tdata), .m_tlast(b_tlast), .full_banks(b_full), .overflow(b_ovf), .drop_cnt(b_drop));

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic b_seen_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every presented word is compared with the queue head, so a stalled word must hold its value.
    always @(negedge clk_50m) begin
        if (usr_rst_n && a_tvalid) begin
            if (a_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected: got word 0x%0h, expected no word", a_tdata);
            end else begin
                chk("a_tdata", 32'(a_tdata), 32'(a_q[0].dat));
                chk("a_tlast", 32'(a_tlast), 32'(a_q[0].last));
                if (a_tready) void'(a_q.pop_front());
            end
        end
    end

    always @(negedge clk_50m) begin
        if (usr_rst_n && b_tvalid) begin
            if (!b_run_en) b_seen_vld = 1'b1;
            if (b_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected: got word 0x%0h, expected no word", b_tdata);
            end else begin
                chk("b_tdata", 32'(b_tdata), 32'(b_q[0].dat));
                chk("b_tlast", 32'(b_tlast), 32'(b_q[0].last));
                if (b_tready) void'(b_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    task automatic a_write(input logic [7:0] d, input bit keep, input bit last);
        a_wr_valid = 1'b1;
        a_wr_data  = d;
        if (keep) a_q.push_back(exp_t'{dat: d, last: last});
        @(posedge clk_50m);
        #1;
        a_wr_valid = 1'b0;
    endtask

    task automatic b_write(input logic [7:0] d, input bit last);
        b_wr_valid = 1'b1;
        b_wr_data  = d;
        b_q.push_back(exp_t'{dat: d, last: last});
        @(posedge clk_50m);
        #1;
        b_wr_valid = 1'b0;
    endtask

    task automatic a_drain(input int max_cyc, input string name);
        int n = 0;
        while (a_q.size() != 0 && n < max_cyc) begin
            tick(1);
            n++;
        end
        chk(name, 32'(a_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        usr_rst_n  = 1'b0;
        a_soft_rst = 1'b0; a_run_en = 1'b1; a_wr_valid = 1'b0; a_wr_data = '0; a_tready = 1'b1;
        b_soft_rst = 1'b0; b_run_en = 1'b0; b_wr_valid = 1'b0; b_wr_data = '0; b_tready = 1'b1;
        tick(3);
        chk("rst_tvalid", 32'(a_tvalid), 32'd0);
        chk("rst_tdata",  32'(a_tdata),  32'd0);
        chk("rst_tlast",  32'(a_tlast),  32'd0);
        chk("rst_full",   32'(a_full),   32'd0);
        chk("rst_ovf",    32'(a_ovf),    32'd0);
        chk("rst_drop",   32'(a_drop),   32'd0);
        chk("rst_b_full", 32'(b_full),   32'd0);
        usr_rst_n = 1'b1;
        tick(2);

        // One bank, latency and back-to-back drain.
        for (int i = 0; i < 16; i++) a_write(8'(i), 1'b1, i == 15);
        chk("t1_vld_e0", 32'(a_tvalid), 32'd0);
        chk("t1_full",   32'(a_full),   32'd1);
        tick(1);
        chk("t1_vld_e1", 32'(a_tvalid), 32'd0);
        tick(1);
        chk("t1_vld_e2", 32'(a_tvalid), 32'd1);
        tick(16);
        chk("t1_qsize",    32'(a_q.size()), 32'd0);
        chk("t1_vld_end",  32'(a_tvalid),   32'd0);
        chk("t1_full_end", 32'(a_full),     32'd0);

        // Paced 64-word stream across four bank fills.
        for (int i = 0; i < 64; i++) begin
            a_write(8'(i), 1'b1, (i % 16) == 15);
            tick(1);
        end
        a_drain(100, "t2_drain");
        chk("t2_drop", 32'(a_drop), 32'd0);
        chk("t2_ovf",  32'(a_ovf),  32'd0);
        tick(2);
        chk("t2_full", 32'(a_full), 32'd0);

        // Stalled output: both banks fill, words 32..39 dropped.
        a_tready = 1'b0;
        for (int i = 0; i < 40; i++) a_write(8'(i), i < 32, (i % 16) == 15);
        chk("t3_ovf",  32'(a_ovf),  32'd1);
        chk("t3_drop", 32'(a_drop), 32'd8);
        chk("t3_full", 32'(a_full), 32'd2);
        a_tready = 1'b1;
        a_drain(200, "t3_drain");
        tick(2);
        chk("t3_full_end", 32'(a_full), 32'd0);
        tick(3);

        // Random backpressure during drain.
        a_tready = 1'b0;
        for (int i = 0; i < 32; i++) a_write(8'h40 + 8'(i), 1'b1, (i % 16) == 15);
        begin
            int n = 0;
            while (a_q.size() != 0 && n < 400) begin
                a_tready = 1'($urandom_range(0, 1));
                tick(1);
                n++;
            end
        end
        a_tready = 1'b1;
        chk("t4_qsize", 32'(a_q.size()), 32'd0);
        chk("t4_drop",  32'(a_drop),     32'd8);
        tick(3);

        // Flush with one bank full, the next half written and word 5 presented.
        a_tready = 1'b0;
        for (int i = 0; i < 16; i++) a_write(8'h60 + 8'(i), 1'b1, i == 15);
        for (int i = 0; i < 8; i++)  a_write(8'h70 + 8'(i), 1'b0, 1'b0);
        a_tready = 1'b1;
        tick(5);
        a_tready = 1'b0;
        chk("t5_presented", 32'(a_tdata), 32'h65);
        a_soft_rst = 1'b1;
        tick(1);
        a_soft_rst = 1'b0;
        a_q.delete();
        chk("t5_tvalid", 32'(a_tvalid), 32'd0);
        chk("t5_tlast",  32'(a_tlast),  32'd0);
        chk("t5_full",   32'(a_full),   32'd0);
        chk("t5_ovf",    32'(a_ovf),    32'd0);
        chk("t5_drop",   32'(a_drop),   32'd0);
        a_tready = 1'b1;
        for (int i = 0; i < 16; i++) a_write(8'h80 + 8'(i), 1'b1, i == 15);
        a_drain(100, "t5_drain");
        tick(2);
        chk("t5_full_end", 32'(a_full), 32'd0);

        // Four banks held by run_en=0, then released.
        for (int i = 0; i < 48; i++) b_write(8'(i), (i % 16) == 15);
        tick(4);
        chk("t6_full",   32'(b_full),     32'd3);
        chk("t6_no_vld", 32'(b_tvalid),   32'd0);
        chk("t6_seen",   32'(b_seen_vld), 32'd0);
        b_run_en = 1'b1;
        begin
            int n = 0;
            while (b_q.size() != 0 && n < 200) begin
                tick(1);
                n++;
            end
        end
        chk("t6_drain", 32'(b_q.size()), 32'd0);
        tick(2);
        chk("t6_full_end", 32'(b_full), 32'd0);
        chk("t6_drop",     32'(b_drop), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
